// File: rtl/est_interp_pkg.sv
// Shared definitions for the channel-estimate interpolator: FSM encoding,
// anchor/segment counts and the per-stream sample count.
package est_interp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_ANCHORS = 4;
    localparam int NUM_SEG     = 3;

    // Three interpolated segments of 2^seg_log2 points plus the closing anchor.
    function automatic int total_samples(input int seg_log2);
        return NUM_SEG * (1 << seg_log2) + 1;
    endfunction

endpackage

// File: rtl/est_interp_lane.sv
// One component (real or imag) of the interpolator: anchor snapshot, accumulator
// and slope. Output rounding is selected by EST_INTERP_ROUND_EN (truncation if undefined).
module est_interp_lane
    import est_interp_pkg::*;
#(
    parameter int WIDTH_EST = 17,
    parameter int SEG_LOG2  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_i,
    input  logic                        step_i,
    input  logic                        next_seg_i,
    input  logic [1:0]                  seg_i,
    input  logic signed [WIDTH_EST-1:0] e_i [NUM_ANCHORS],
    output logic signed [WIDTH_EST-1:0] h_o
);

    localparam int AW = WIDTH_EST + SEG_LOG2 + 2;
    localparam int DW = WIDTH_EST + 1;

    logic signed [WIDTH_EST-1:0] snap_q [NUM_ANCHORS];
    logic signed [AW-1:0]        acc_q, acc_d;
    logic signed [DW-1:0]        diff_q, diff_d;
    logic signed [WIDTH_EST-1:0] anc_cur, anc_nxt;
    logic signed [AW-1:0]        acc_r;

    function automatic logic signed [AW-1:0] anchor_acc(input logic signed [WIDTH_EST-1:0] v);
        logic signed [AW-1:0] ext;
        ext = {{(AW-WIDTH_EST){v[WIDTH_EST-1]}}, v};
        return ext <<< SEG_LOG2;
    endfunction

    function automatic logic signed [DW-1:0] slope(input logic signed [WIDTH_EST-1:0] hi,
                                                   input logic signed [WIDTH_EST-1:0] lo);
        return {hi[WIDTH_EST-1], hi} - {lo[WIDTH_EST-1], lo};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ANCHORS; i++) begin
                snap_q[i] <= '0;
            end
            acc_q  <= '0;
            diff_q <= '0;
        end else begin
            if (load_i) begin
                for (int i = 0; i < NUM_ANCHORS; i++) begin
                    snap_q[i] <= e_i[i];
                end
            end
            acc_q  <= acc_d;
            diff_q <= diff_d;
        end
    end

    // Segment 3 is the closing anchor alone, so its slope is never used.
    always_comb begin
        acc_d   = acc_q;
        diff_d  = diff_q;
        anc_cur = snap_q[seg_i];
        anc_nxt = snap_q[seg_i + 2'd1];
        if (load_i) begin
            acc_d  = anchor_acc(e_i[0]);
            diff_d = slope(e_i[1], e_i[0]);
        end else if (next_seg_i) begin
            acc_d  = anchor_acc(anc_cur);
            diff_d = (seg_i == 2'd3) ? '0 : slope(anc_nxt, anc_cur);
        end else if (step_i) begin
            acc_d = acc_q + {{(AW-DW){diff_q[DW-1]}}, diff_q};
        end
    end

`ifdef EST_INTERP_ROUND_EN
    // The offset is below one output LSB, so an exact anchor still maps to itself.
    localparam logic signed [AW-1:0] HALF = AW'(1) <<< (SEG_LOG2 - 1);
    assign acc_r = acc_q + HALF;
`else
    assign acc_r = acc_q;
`endif

    assign h_o = WIDTH_EST'(acc_r >>> SEG_LOG2);

endmodule

// File: rtl/est_interp.sv
// Channel-estimate interpolator: snapshots E1..E4 on start and streams 3N+1
// interpolated coefficients over valid/ready. Optional macro: EST_INTERP_ROUND_EN.
module est_interp
    import est_interp_pkg::*;
#(
    parameter int WIDTH_EST = 17,
    parameter int SEG_LOG2  = 2,
    parameter int IDX_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [WIDTH_EST-1:0] e1_re,
    input  logic signed [WIDTH_EST-1:0] e2_re,
    input  logic signed [WIDTH_EST-1:0] e3_re,
    input  logic signed [WIDTH_EST-1:0] e4_re,
    input  logic signed [WIDTH_EST-1:0] e1_im,
    input  logic signed [WIDTH_EST-1:0] e2_im,
    input  logic signed [WIDTH_EST-1:0] e3_im,
    input  logic signed [WIDTH_EST-1:0] e4_im,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic signed [WIDTH_EST-1:0] h_re,
    output logic signed [WIDTH_EST-1:0] h_im,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int LAST_IDX = total_samples(SEG_LOG2) - 1;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [SEG_LOG2-1:0]         j_q, j_d;
    logic [1:0]                  k_q, k_d;
    logic                        load_stb, step_stb, next_seg_stb;
    logic [1:0]                  seg_sel;
    logic signed [WIDTH_EST-1:0] est [2][NUM_ANCHORS];
    logic signed [WIDTH_EST-1:0] h_lane [2];

    assign est[0][0] = e1_re;
    assign est[0][1] = e2_re;
    assign est[0][2] = e3_re;
    assign est[0][3] = e4_re;
    assign est[1][0] = e1_im;
    assign est[1][1] = e2_im;
    assign est[1][2] = e3_im;
    assign est[1][3] = e4_im;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // j counts points within the segment; k is the segment, with k=3 the closing E4 sample.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        j_d          = j_q;
        k_d          = k_q;
        load_stb     = 1'b0;
        step_stb     = 1'b0;
        next_seg_stb = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_stb = 1'b1;
                idx_d    = '0;
                j_d      = '0;
                k_d      = '0;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (j_q == {SEG_LOG2{1'b1}}) begin
                            j_d          = '0;
                            k_d          = k_q + 2'd1;
                            next_seg_stb = 1'b1;
                        end else begin
                            j_d      = j_q + 1'b1;
                            step_stb = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign seg_sel = k_q + 2'd1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            est_interp_lane #(
                .WIDTH_EST (WIDTH_EST),
                .SEG_LOG2  (SEG_LOG2)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .load_i     (load_stb),
                .step_i     (step_stb),
                .next_seg_i (next_seg_stb),
                .seg_i      (seg_sel),
                .e_i        (est[gi]),
                .h_o        (h_lane[gi])
            );
        end
    endgenerate

    assign h_re      = h_lane[0];
    assign h_im      = h_lane[1];
    assign out_idx   = idx_q;
    assign out_valid = (state_q == ST_STREAM);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_STREAM);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_est_interp.sv
// Directed self-checking bench for est_interp (WIDTH_EST=17, SEG_LOG2=2, IDX_W=5).
module tb_est_interp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic signed [16:0] e1_re = '0, e2_re = '0, e3_re = '0, e4_re = '0;
    logic signed [16:0] e1_im = '0, e2_im = '0, e3_im = '0, e4_im = '0;
    logic out_valid;
    logic signed [16:0] h_re, h_im;
    logic [4:0] out_idx;
    logic busy, done;

    int tests = 0;
    int fails = 0;

    logic signed [16:0] cap_re [16];
    logic signed [16:0] cap_im [16];
    logic [4:0]         cap_idx [16];
    int cap_n, first_valid, last_hs, done_cyc, hold_err, busy_err;
    bit tmo;

    est_interp #(.WIDTH_EST(17), .SEG_LOG2(2), .IDX_W(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .e1_re(e1_re), .e2_re(e2_re), .e3_re(e3_re), .e4_re(e4_re),
        .e1_im(e1_im), .e2_im(e2_im), .e3_im(e3_im), .e4_im(e4_im),
        .out_ready(out_ready), .out_valid(out_valid),
        .h_re(h_re), .h_im(h_im), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic set_est(input int r1, input int r2, input int r3, input int r4,
                           input int i1, input int i2, input int i3, input int i4);
        e1_re = 17'(r1); e2_re = 17'(r2); e3_re = 17'(r3); e4_re = 17'(r4);
        e1_im = 17'(i1); e2_im = 17'(i2); e3_im = 17'(i3); e4_im = 17'(i4);
    endtask

    // Pulses start and records every accepted sample; called at posedge+1.
    // mode 1 drives ready as 1,0,0,1,... ; scramble changes e* after LOAD and re-pulses start.
    task automatic run_stream(input int mode, input bit scramble);
        logic signed [16:0] pre_re, pre_im;
        logic [4:0] pre_idx;
        bit pend;
        cap_n = 0; first_valid = -1; last_hs = -1; done_cyc = -1;
        hold_err = 0; busy_err = 0; tmo = 0; pend = 0;
        pre_re = '0; pre_im = '0; pre_idx = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            if (pend && (h_re !== pre_re || h_im !== pre_im || out_idx !== pre_idx || out_valid !== 1'b1))
                hold_err++;
            pend = 0;
            out_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            start = scramble && (cyc == 5);
            if (scramble && cyc >= 1) begin
                e1_re = 17'($urandom); e2_re = 17'($urandom); e3_re = 17'($urandom); e4_re = 17'($urandom);
                e1_im = 17'($urandom); e2_im = 17'($urandom); e3_im = 17'($urandom); e4_im = 17'($urandom);
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                if (busy !== 1'b1) busy_err++;
                if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
                if (out_valid === 1'b1 && out_ready && cap_n < 16) begin
                    cap_re[cap_n] = h_re; cap_im[cap_n] = h_im; cap_idx[cap_n] = out_idx;
                    cap_n++;
                    last_hs = cyc;
                end
                if (out_valid === 1'b1 && !out_ready) begin
                    pend = 1; pre_re = h_re; pre_im = h_im; pre_idx = out_idx;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (done_cyc < 0) tmo = 1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || h_re !== 17'sd0 || h_im !== 17'sd0 || out_idx !== 5'd0) begin
            fails++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b h_re=%0d h_im=%0d idx=%0d, required all 0",
                     out_valid, busy, done, h_re, h_im, out_idx);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset: outputs idle");
    endtask

    task automatic test_stream();
        int exp_re [13] = '{0, 25, 50, 75, 100, 50, 0, -50, -100, -65, -30, 5, 40};
        set_est(0, 100, -100, 40, 0, -100, 100, -40);
        run_stream(0, 1'b0);
        tests++;
        if (tmo || cap_n != 13) begin
            fails++;
            $display("FAIL stream_count: got %0d samples (timeout=%0d), required 13", cap_n, tmo);
        end
        tests++;
        if (first_valid != 1) begin
            fails++;
            $display("FAIL stream_latency: first valid %0d cycles after LOAD, required 1", first_valid);
        end
        for (int i = 0; i < 13 && i < cap_n; i++) begin
            tests++;
            if (cap_re[i] !== 17'(exp_re[i]) || cap_im[i] !== 17'(-exp_re[i]) || cap_idx[i] !== 5'(i)) begin
                fails++;
                $display("FAIL stream_sample[%0d]: h_re=%0d h_im=%0d idx=%0d, required %0d %0d %0d",
                         i, cap_re[i], cap_im[i], cap_idx[i], exp_re[i], -exp_re[i], i);
            end
            $display("[TB] stream sample idx=%0d h_re=%0d h_im=%0d", cap_idx[i], cap_re[i], cap_im[i]);
        end
        tests++;
        if (done_cyc != last_hs + 1 || busy_err != 0) begin
            fails++;
            $display("FAIL stream_done: done at %0d, last handshake %0d, busy drops %0d, required done one cycle later, 0 drops",
                     done_cyc, last_hs, busy_err);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL done_busy: busy=%b during done, required 0", busy);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b busy=%b valid=%b after pulse, required 0 0 0", done, busy, out_valid);
        end
    endtask

    task automatic test_truncation();
`ifdef EST_INTERP_ROUND_EN
        int exp_pos [4] = '{0, 1, 2, 2};
        int exp_neg [4] = '{0, -1, -1, -2};
`else
        int exp_pos [4] = '{0, 0, 1, 2};
        int exp_neg [4] = '{0, -1, -2, -3};
`endif
        set_est(0, 3, 0, 0, 0, 0, 0, 0);
        run_stream(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cap_re[i] !== 17'(exp_pos[i])) begin
                fails++;
                $display("FAIL trunc_pos[%0d]: h_re=%0d, required %0d", i, cap_re[i], exp_pos[i]);
            end
            $display("[TB] trunc +3 idx=%0d h_re=%0d", i, cap_re[i]);
        end
        @(posedge clk); #1;
        set_est(0, -3, 0, 0, 0, 0, 0, 0);
        run_stream(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cap_re[i] !== 17'(exp_neg[i])) begin
                fails++;
                $display("FAIL trunc_neg[%0d]: h_re=%0d, required %0d", i, cap_re[i], exp_neg[i]);
            end
            $display("[TB] trunc -3 idx=%0d h_re=%0d", i, cap_re[i]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int exp_re [13] = '{0, 25, 50, 75, 100, 50, 0, -50, -100, -65, -30, 5, 40};
        set_est(0, 100, -100, 40, 0, -100, 100, -40);
        run_stream(1, 1'b0);
        tests++;
        if (tmo || cap_n != 13 || hold_err != 0) begin
            fails++;
            $display("FAIL bp_hold: samples=%0d hold_violations=%0d timeout=%0d, required 13 0 0", cap_n, hold_err, tmo);
        end
        for (int i = 0; i < 13 && i < cap_n; i++) begin
            tests++;
            if (cap_re[i] !== 17'(exp_re[i]) || cap_im[i] !== 17'(-exp_re[i]) || cap_idx[i] !== 5'(i)) begin
                fails++;
                $display("FAIL bp_sample[%0d]: h_re=%0d h_im=%0d idx=%0d, required %0d %0d %0d",
                         i, cap_re[i], cap_im[i], cap_idx[i], exp_re[i], -exp_re[i], i);
            end
            $display("[TB] backpressure idx=%0d h_re=%0d", cap_idx[i], cap_re[i]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_snapshot();
        int exp_re [13] = '{0, 25, 50, 75, 100, 50, 0, -50, -100, -65, -30, 5, 40};
        set_est(0, 100, -100, 40, 0, -100, 100, -40);
        run_stream(0, 1'b1);
        tests++;
        if (tmo || cap_n != 13 || busy_err != 0) begin
            fails++;
            $display("FAIL snap_stream: samples=%0d busy_drops=%0d timeout=%0d, required 13 0 0", cap_n, busy_err, tmo);
        end
        for (int i = 0; i < 13 && i < cap_n; i++) begin
            tests++;
            if (cap_re[i] !== 17'(exp_re[i]) || cap_im[i] !== 17'(-exp_re[i]) || cap_idx[i] !== 5'(i)) begin
                fails++;
                $display("FAIL snap_sample[%0d]: h_re=%0d h_im=%0d idx=%0d, required %0d %0d %0d",
                         i, cap_re[i], cap_im[i], cap_idx[i], exp_re[i], -exp_re[i], i);
            end
            $display("[TB] snapshot idx=%0d h_re=%0d h_im=%0d", cap_idx[i], cap_re[i], cap_im[i]);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL snap_restart: busy=%b valid=%b after stream, required 0 0 (mid-stream start ignored)", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int exp_re [13] = '{0, 25, 50, 75, 100, 50, 0, -50, -100, -65, -30, 5, 40};
        bit seen_done;
        bit reached;
        set_est(0, 100, -100, 40, 0, -100, 100, -40);
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reached = 0;
        for (int c = 0; c < 40 && !reached; c++) begin
            if (out_valid === 1'b1 && out_idx === 5'd6) reached = 1;
            else begin @(posedge clk); #1; end
        end
        tests++;
        if (!reached) begin
            fails++;
            $display("FAIL rstmid_reach: out_idx=%0d, required to reach 6", out_idx);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || h_re !== 17'sd0 || h_im !== 17'sd0 || out_idx !== 5'd0) begin
            fails++;
            $display("FAIL rstmid_clear: valid=%b busy=%b h_re=%0d h_im=%0d idx=%0d, required all 0",
                     out_valid, busy, h_re, h_im, out_idx);
        end
        seen_done = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen_done = 1;
        end
        rst = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen_done = 1;
        end
        tests++;
        if (seen_done) begin
            fails++;
            $display("FAIL rstmid_nodone: done pulse seen after reset, required none");
        end
        $display("[TB] reset mid-stream at idx 6, outputs cleared");
        run_stream(0, 1'b0);
        tests++;
        if (tmo || cap_n != 13 || cap_idx[0] !== 5'd0 || cap_re[0] !== 17'sd0 || cap_re[4] !== 17'(exp_re[4]) || cap_re[12] !== 17'(exp_re[12])) begin
            fails++;
            $display("FAIL rstmid_restart: samples=%0d idx0=%0d re0=%0d re4=%0d re12=%0d, required 13 0 0 100 40",
                     cap_n, cap_idx[0], cap_re[0], cap_re[4], cap_re[12]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lanes();
`ifdef EST_INTERP_ROUND_EN
        int exp_im [13] = '{-65536, -32768, 0, 32767, 65535, 49151, 32768, 16384, 0, 0, 0, -1, -1};
`else
        int exp_im [13] = '{-65536, -32769, -1, 32767, 65535, 49151, 32767, 16383, 0, -1, -1, -1, -1};
`endif
        set_est(0, 0, 0, 0, -65536, 65535, 0, -1);
        run_stream(0, 1'b0);
        tests++;
        if (tmo || cap_n != 13) begin
            fails++;
            $display("FAIL lanes_count: samples=%0d timeout=%0d, required 13", cap_n, tmo);
        end
        for (int i = 0; i < 13 && i < cap_n; i++) begin
            tests++;
            if (cap_re[i] !== 17'sd0 || cap_im[i] !== 17'(exp_im[i])) begin
                fails++;
                $display("FAIL lanes_sample[%0d]: h_re=%0d h_im=%0d, required 0 %0d", i, cap_re[i], cap_im[i], exp_im[i]);
            end
            $display("[TB] lanes idx=%0d h_re=%0d h_im=%0d", cap_idx[i], cap_re[i], cap_im[i]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_truncation();
        test_backpressure();
        test_snapshot();
        test_reset_mid();
        test_lanes();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/est_interp.md
Name: est_interp

Overview:
- Reader side of the per-pilot channel-estimate store. It snapshots the four averaged estimates E1..E4 (real and imag) on a start pulse.
- It then streams linearly interpolated channel coefficients to the equalizer over a valid/ready handshake.
- Sits between the channel-estimation averaging stage and the equalizer.

Parameters:
- WIDTH_EST, 17, width of each estimate and of each output sample (two's complement signed).
- SEG_LOG2, 2, log2 of points per interpolation segment (legal range 1..3); N = 2^SEG_LOG2.
- IDX_W, 5, width of out_idx; must hold 3*N.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; snapshot estimates and begin stream
- e1_re, e2_re, e3_re, e4_re  in  WIDTH_EST each  real estimates from store
- e1_im, e2_im, e3_im, e4_im  in  WIDTH_EST each  imag estimates from store
- out_ready  in  1  consumer accepts current sample
- out_valid  out  1  h_re/h_im/out_idx valid
- h_re  out  WIDTH_EST  interpolated real coefficient
- h_im  out  WIDTH_EST  interpolated imag coefficient
- out_idx  out  IDX_W  sample index 0..3N
- busy  out  1  high from start acceptance until last sample accepted
- done  out  1  one-cycle pulse after last sample accepted

Behaviour:
- Reset (rst low, async): state IDLE; out_valid, busy, done, h_re, h_im, out_idx all 0; snapshot registers 0.
- FSM states:
  - IDLE: start=1 -> LOAD; busy=1 next cycle.
  - LOAD: one cycle. Capture e1..e4 re/im into local regs. Segment k=0. acc = E1 << SEG_LOG2. diff = E2 - E1, sign-extended to WIDTH_EST+1. -> STREAM.
  - STREAM: out_valid=1. Outputs are held stable while out_ready=0.
    - On handshake (out_valid & out_ready): out_idx++, acc += diff.
    - After N accepted samples in segment k: k++, acc = E(k+1) << SEG_LOG2, diff = E(k+2) - E(k+1).
    - After segment 2 completes (3N samples): emit final sample = E4 exactly, out_idx = 3N.
    - Handshake on the final sample -> DONE.
  - DONE: one cycle. done=1, busy=0, out_valid=0 -> IDLE.
- Sample value: h = acc >>> SEG_LOG2, arithmetic shift, truncation toward -inf. This gives E_k + floor(j*diff/N), j = 0..N-1.
- acc width: WIDTH_EST + SEG_LOG2 + 2. No saturation is needed; results are bounded by [min(Ek, Ek+1), max(Ek, Ek+1)].
- Latency: start in cycle t -> first out_valid in cycle t+2. One sample per cycle when out_ready is held high. Total 3N+1 samples.
- start while busy or in DONE: ignored. No restart, no error flag.
- Inputs e* are sampled only in LOAD. Writes to the store during streaming have no effect on the current stream.
- rst asserted mid-stream: immediate return to IDLE, outputs cleared, no done pulse.
- out_ready high while out_valid low: no effect.

Optional Feature:
- Macro EST_INTERP_ROUND_EN.
- When defined: h = (acc + 2^(SEG_LOG2-1)) >>> SEG_LOG2, i.e. round-half-up. The final sample is still exactly E4.
- When undefined: truncation as above. Latency, handshake and ports are identical in both builds.

Decomposition:
- Shared package contents:
  - FSM state encoding (IDLE, LOAD, STREAM, DONE).
  - NUM_ANCHORS = 4 and NUM_SEG = 3.
  - Function computing total sample count 3*2^SEG_LOG2 + 1.
- Sub-module est_interp_lane, instantiated twice (real, imag):
  - Holds the 4 snapshot regs, acc and diff.
  - Driven by shared load/step/next_seg strobes and segment index from the top-level FSM.
  - Top level owns FSM, counters and handshake.

Test Plan:
- SEG_LOG2=2, re E=0,100,-100,40, out_ready=1, start pulse -> first valid 2 cycles later. h_re = 0,25,50,75,100,50,0,-50,-100,-65,-30,5,40; out_idx 0..12; done pulse one cycle after the idx-12 handshake.
- Truncation: re E1=0, E2=3 -> segment 0 gives 0,0,1,2. With E2=-3 -> 0,-1,-2,-3. With EST_INTERP_ROUND_EN, E2=3 -> 0,1,2,2.
- Backpressure: toggle out_ready 1,0,0,1,… -> h_re/h_im/out_idx held stable while ready=0. The sequence is identical to the ready=1 case, with no skipped or duplicated idx.
- Snapshot isolation: change e1..e4 inputs every cycle during STREAM -> output stream matches values present in LOAD. A second start pulse mid-stream is ignored; busy stays 1.
- Reset mid-stream: assert rst at out_idx=6 -> out_valid, busy, h_re, h_im, out_idx go to 0 asynchronously, no done. A new start after release streams from idx 0.
- Independent lanes: im E=-65536,65535,0,-1 with re all 0 -> h_re all 0. h_im follows interpolation with no overflow (WIDTH_EST=17 extremes).
